// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Data-memory responder for the CPU M stage. Combinational word
//            reads, byte-enabled synchronous writes, and a first-word
//            fall-through trace FIFO recording every committed store.
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_byteen,
  input  logic [31:0]          m_pc,
  output logic [31:0]          m_rdata,
  output logic                 addr_err,
  output logic                 trace_valid,
  input  logic                 trace_ready,
  output logic [31:0]          trace_pc,
  output logic [31:0]          trace_addr,
  output logic [31:0]          trace_data,
  output logic                 trace_overflow,
  output logic [CNT_WIDTH-1:0] fifo_count
);

  localparam int                   c_WORDS   = 1 << ADDR_WIDTH;
  localparam int                   c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_FULL    = CNT_WIDTH'(FIFO_DEPTH);

  logic [31:0]           r_mem [c_WORDS];
  logic [31:0]           r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]           r_fifo_addr [FIFO_DEPTH];
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_overflow;

  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_index;
  logic [31:0]           w_old;
  logic [31:0]           w_merged;
  logic                  w_store;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_push;

  assign w_in_range = (m_addr[31:ADDR_WIDTH+2] == '0);
  assign w_index    = m_addr[ADDR_WIDTH+1:2];
  assign w_old      = r_mem[w_index];

  // Lane-wise merge of store data over the current word contents
  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign w_merged[8*l +: 8] = m_byteen[l] ? m_wdata[8*l +: 8] : w_old[8*l +: 8];
  end

  assign w_store = (m_byteen != 4'b0000) && w_in_range;
  assign w_full  = (r_count == c_FULL);
  assign w_pop   = (r_count != '0) && trace_ready;
  // A full FIFO still accepts the push when the head leaves on the same edge
  assign w_push  = w_store && (!w_full || w_pop);

  assign m_rdata        = w_in_range ? w_old : 32'h0;
  assign addr_err       = !w_in_range;
  assign trace_valid    = (r_count != '0);
  assign trace_pc       = r_fifo_pc[r_rd_ptr];
  assign trace_addr     = r_fifo_addr[r_rd_ptr];
  assign trace_data     = r_fifo_data[r_rd_ptr];
  assign trace_overflow = r_overflow;
  assign fifo_count     = r_count;

  // Memory array: cleared on reset, merged word written on an in-range store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < c_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_store) begin
      r_mem[w_index] <= w_merged;
    end
  end

  // Trace FIFO storage, pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_addr[i] <= '0;
        r_fifo_data[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]   <= m_pc;
        r_fifo_addr[r_wr_ptr] <= m_addr & 32'hFFFF_FFFC;
        r_fifo_data[r_wr_ptr] <= w_merged;
        r_wr_ptr              <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
      if (w_store && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder: the memory end of the pipeline's M-stage data-memory interface.
- Serves combinational word reads and byte-enabled synchronous writes from the CPU.
- Records every committed store in a trace FIFO, drained through a valid/ready handshake by the testbench/trace logger.
- Sits beside the CPU core; its m_rdata feeds the core's M-stage load-extension logic.

Parameters:
ADDR_WIDTH, 12, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words (byte range 0 .. 4*2^ADDR_WIDTH-1)
FIFO_DEPTH, 8, trace FIFO entries; power of two, >=2
CNT_WIDTH, 4, width of fifo_count; must hold FIFO_DEPTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
m_addr  input  32  byte address from CPU M stage
m_wdata  input  32  lane-aligned store data
m_byteen  input  4  byte-lane write enables; bit i writes bits [8i+7:8i]; 0 = no store
m_pc  input  32  PC of the instruction in M stage
m_rdata  output  32  word at m_addr, combinational
addr_err  output  1  combinational; 1 when m_addr is outside the memory range
trace_valid  output  1  FIFO head entry valid
trace_ready  input  1  consumer accepts head entry
trace_pc  output  32  PC of head store
trace_addr  output  32  word-aligned address of head store ({addr[31:2],2'b00})
trace_data  output  32  full merged word after the store
trace_overflow  output  1  sticky; a store trace was dropped
fifo_count  output  CNT_WIDTH  current FIFO occupancy

Behaviour:
- Reset (rst=0, async):
  - every memory word cleared to 0
  - FIFO empty; read/write pointers 0
  - trace_valid=0, trace_overflow=0, fifo_count=0
  - trace_pc/addr/data = 0
  - Takes effect immediately mid-operation; an in-flight store is lost.
- In range: m_addr[31:ADDR_WIDTH+2]==0. Word index = m_addr[ADDR_WIDTH+1:2]; m_addr[1:0] ignored for indexing.
- Read: m_rdata = mem[index], pure combinational, zero latency.
  - Out of range: m_rdata=0, addr_err=1.
  - A store in the same cycle is not visible until after the edge (read-old).
- Store commit: at posedge when m_byteen!=0 and in range.
  - Only enabled lanes are replaced; other lanes unchanged.
  - merged = per-lane select of m_wdata vs old mem[index].
  - Any byteen pattern is applied lane-wise; no legality check.
  - Out-of-range store: memory unchanged, no trace push.
- Trace push: same edge as the commit, entry {m_pc, word-aligned m_addr, merged}.
- Trace pop: at posedge when trace_valid && trace_ready.
- FIFO is first-word fall-through: trace_* always reflect the head entry; trace_valid = (fifo_count!=0).
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - When full this is legal; no overflow.
  - When empty, the pop is not possible (trace_valid=0); push only.
- Full with push and no pop: entry dropped, trace_overflow set to 1. It stays 1 until reset.
- Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- trace_ready while empty: no effect.
- Back-to-back stores to the same word: the second merge uses the first store's result (each edge updates the array before the next read).

Test Plan:
- Reset then read addr 0x0000_0010 -> m_rdata=0, addr_err=0, trace_valid=0, fifo_count=0.
- Store byteen=1111 data 0x12345678 addr 0x20 pc 0x3000; next cycle byteen=0001 data 0x000000AB addr 0x20 -> mem word = 0x123456AB. Trace entries in order: (0x3000,0x20,0x12345678) then (pc,0x20,0x123456AB).
- Store byteen=1100 data 0xBEEF0000 at addr 0x42 onto word 0x11223344 -> word 0xBEEF3344; trace_addr=0x40.
- trace_ready=0, issue FIFO_DEPTH+1 stores -> fifo_count=8, trace_overflow=1, the 9th store's data is still in memory. Drain 8 entries with trace_ready=1 -> pops in issue order, count reaches 0, overflow stays 1.
- FIFO full, store with trace_ready=1 in the same cycle -> count stays 8, no overflow, new entry at tail.
- Store to addr 0x0000_4000 (out of range, ADDR_WIDTH=12) -> addr_err=1, m_rdata=0, no push, memory unchanged.
- Assert rst=0 mid-cycle while FIFO holds 3 entries -> trace_valid drops immediately, count=0, memory reads 0.
